rr_arbiter_8: RTL and testbench

- Sequential 8-way round-robin arbiter that shares a single resource among 8 requesters.
- Produces a registered one-hot grant plus a matching 3-bit binary grant index.
- The index drives the shared resource's select logic; the one-hot grant returns to the requesters.
- Grants are held while the owner keeps requesting, bounded by a programmable hold limit for fairness.

---
 rtl/rr_arbiter_8.sv | 141 ++++++++++++++
 tb/tb_rr_arbiter_8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index
// and a per-tenure hold counter that bounds ownership while others wait.
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       req,
   output logic [7:0]       gnt,
   output logic [2:0]       gnt_idx,
   output logic             gnt_valid,
   output logic [CNT_W-1:0] hold_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [2:0]       ptr_q, ptr_d;

   logic [7:0]       pick_req;
   logic [2:0]       pick_ptr;
   logic             pick_found;
   logic [2:0]       pick_idx;
   logic             owner_req;
   logic [7:0]       others;
   logic             timeout_hit;

   // First set bit of r in the order p+1, p+2, ..., p+8 (mod 8).
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] i;
      res = '0;
      for (int unsigned k = 1; k <= 8; k++) begin
         i = p + 3'(k);
         if (!res[3] && r[i]) begin
            res = {1'b1, i};
         end
      end
      return res;
   endfunction

   always_comb begin
      owner_req   = req[idx_q];
      others      = req & ~gnt_q;
      timeout_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

      // A single search serves all cases: in GRANT the owner sits at ptr
      // (lowest priority) and is masked out when it is still requesting.
      pick_req = req;
      pick_ptr = ptr_q;
      if (state_q == GRANT) begin
         pick_req = owner_req ? others : req;
         pick_ptr = idx_q;
      end
      {pick_found, pick_idx} = rr_pick(pick_req, pick_ptr);
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               gnt_d   = 8'b1 << pick_idx;
               idx_d   = pick_idx;
               valid_d = 1'b1;
               hold_d  = '0;
               ptr_d   = pick_idx;
            end
         end
         GRANT: begin
            if (!owner_req || (timeout_hit && (others != '0))) begin
               if (pick_found) begin
                  gnt_d   = 8'b1 << pick_idx;
                  idx_d   = pick_idx;
                  valid_d = 1'b1;
                  hold_d  = '0;
                  ptr_d   = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
                  hold_d  = '0;
               end
            end else if (timeout_hit) begin
               hold_d = '0;
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         hold_q  <= '0;
         ptr_q   <= 3'd7;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign hold_cnt  = hold_q;

   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
   a_valid   : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (gnt_q != '0));
   a_index   : assert property (@(posedge clk) disable iff (!rst_n)
                                valid_q |-> (gnt_q == (8'b1 << idx_q)));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench: four arbiters with different hold limits share one
// request/reset stream and are checked against a behavioural model.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;

   logic [7:0] g   [4];
   logic [2:0] gi  [4];
   logic       gv  [4];
   logic [3:0] hc0;
   logic [2:0] hc1;
   logic [1:0] hc2;
   logic [2:0] hc3;

   rr_arbiter_8 #(.MAX_HOLD(15), .CNT_W(4)) u_mh15 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(g[0]), .gnt_idx(gi[0]),
      .gnt_valid(gv[0]), .hold_cnt(hc0));
   rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(3)) u_mh4 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(g[1]), .gnt_idx(gi[1]),
      .gnt_valid(gv[1]), .hold_cnt(hc1));
   rr_arbiter_8 #(.MAX_HOLD(2), .CNT_W(2)) u_mh2 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(g[2]), .gnt_idx(gi[2]),
      .gnt_valid(gv[2]), .hold_cnt(hc2));
   rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(3)) u_mh0 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(g[3]), .gnt_idx(gi[3]),
      .gnt_valid(gv[3]), .hold_cnt(hc3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][7:0] gnt;
      logic [3:0][2:0] idx;
      logic [3:0]      vld;
      logic [3:0][3:0] hold;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Behavioural model: owner -1 means idle; tenure counts cycles owned.
   int mh   [4] = '{15, 4, 2, 0};
   int hmax [4] = '{15, 7, 3, 7};
   int own  [4];
   int ten  [4];
   int ptr  [4];
   int lidx [4];

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 1; k <= 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [7:0] r, input logic rn);
      exp_t e;
      int   w;
      logic [7:0] oth;
      for (int d = 0; d < 4; d++) begin
         if (!rn) begin
            own[d] = -1; ten[d] = 0; ptr[d] = 7; lidx[d] = 0;
         end else if (own[d] < 0) begin
            w = pick(r, ptr[d]);
            if (w >= 0) begin
               own[d] = w; ten[d] = 0; ptr[d] = w; lidx[d] = w;
            end
         end else begin
            oth = r;
            oth[own[d]] = 1'b0;
            if (!r[own[d]]) begin
               w = pick(r, own[d]);
               if (w >= 0) begin
                  own[d] = w; ten[d] = 0; ptr[d] = w; lidx[d] = w;
               end else begin
                  own[d] = -1; ten[d] = 0;
               end
            end else if (mh[d] != 0 && ten[d] == mh[d] - 1) begin
               if (oth != 0) begin
                  w = pick(oth, own[d]);
                  own[d] = w; ten[d] = 0; ptr[d] = w; lidx[d] = w;
               end else begin
                  ten[d] = 0;
               end
            end else if (ten[d] < hmax[d]) begin
               ten[d] = ten[d] + 1;
            end
         end
         e.gnt[d]  = (own[d] < 0) ? 8'h00 : (8'h01 << own[d]);
         e.idx[d]  = 3'(lidx[d]);
         e.vld[d]  = (own[d] >= 0);
         e.hold[d] = 4'(ten[d]);
      end
      q.push_back(e);
   endtask

   task automatic cyc(input logic [7:0] r, input logic rn);
      req   = r;
      rst_n = rn;
      @(posedge clk);
      model_step(r, rn);
      #2;
   endtask

   // Monitor: outputs are registered, so every cycle presents a result.
   initial begin
      exp_t e;
      int   ah [4];
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            cycle++;
            ah[0] = int'(hc0); ah[1] = int'(hc1); ah[2] = int'(hc2); ah[3] = int'(hc3);
            for (int d = 0; d < 4; d++) begin
               checks++;
               if (g[d] !== e.gnt[d] || gi[d] !== e.idx[d] || gv[d] !== e.vld[d]
                   || ah[d] != int'(e.hold[d])) begin
                  errors++;
                  $display("FAIL grant dut%0d(MAX_HOLD=%0d) cycle %0d: got gnt=%h idx=%0d vld=%b hold=%0d, expected gnt=%h idx=%0d vld=%b hold=%0d",
                           d, mh[d], cycle, g[d], gi[d], gv[d], ah[d],
                           e.gnt[d], e.idx[d], e.vld[d], e.hold[d]);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] cur;
      logic       rn;
      req   = '0;
      rst_n = 1'b0;
      for (int d = 0; d < 4; d++) begin
         own[d] = -1; ten[d] = 0; ptr[d] = 7; lidx[d] = 0;
      end

      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      repeat (5) cyc(8'h00, 1'b1);

      repeat (4) cyc(8'h81, 1'b1);
      repeat (3) cyc(8'h80, 1'b1);
      repeat (2) cyc(8'h00, 1'b1);

      cyc(8'h00, 1'b0);
      repeat (20) cyc(8'h06, 1'b1);
      cyc(8'h00, 1'b0);
      repeat (10) cyc(8'h08, 1'b1);
      cyc(8'h00, 1'b0);
      repeat (140) cyc(8'hFF, 1'b1);

      cyc(8'h00, 1'b0);
      repeat (3) cyc(8'h20, 1'b1);
      cyc(8'h20, 1'b0);
      repeat (3) cyc(8'h21, 1'b1);

      // Level-sensitive glitch on a non-owner, then random traffic.
      repeat (2) cyc(8'h02, 1'b1);
      cyc(8'h06, 1'b1);
      repeat (3) cyc(8'h02, 1'b1);

      cur = 8'h00;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: cur = 8'($urandom);
               1: cur = 8'($urandom) & 8'($urandom) & 8'($urandom);
               default: cur = cur ^ (8'h01 << $urandom_range(0, 7));
            endcase
         end
         rn = ($urandom_range(0, 199) != 0);
         cyc(cur, rn);
      end

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
